// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and helpers for the multi-read-port
//                integer register file (FSM encodings, zero register,
//                address-width helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // CLEAR/RUN state encodings
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // Architectural zero register (hardwired, no storage)
    localparam int REG_ZERO = 0;

    // Address width needed to index n registers (at least one bit)
    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/register_file_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_mp_if
//  Description : Write-port / read-port bundle between decode, writeback
//                and the multi-port register file.
//  Revision    : 1.0 - initial release
// ============================================================================
interface register_file_mp_if
    import regfile_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2
);
    localparam int ADDR_W = addr_w(NUM_REGS);

    logic                           ready;
    logic                           rd_en;
    logic [ADDR_W-1:0]              rd;
    logic [DATA_WIDTH-1:0]          rd_din;
    logic [NUM_READ-1:0]            rs_en;
    logic [NUM_READ*ADDR_W-1:0]     rs_addr;
    logic [NUM_READ*DATA_WIDTH-1:0] rs_dout;
    logic [NUM_READ-1:0]            rs_valid;

    // Pipeline side (decode / writeback)
    modport master (
        input  ready, rs_dout, rs_valid,
        output rd_en, rd, rd_din, rs_en, rs_addr
    );

    // Register file side
    modport slave (
        output ready, rs_dout, rs_valid,
        input  rd_en, rd, rd_din, rs_en, rs_addr
    );

endinterface : register_file_mp_if
`default_nettype wire

// File: rtl/register_file_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_read_port
//  Description : One registered read port: zero-register check, optional
//                write-to-read bypass and the output data/valid registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_read_port
    import regfile_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BYPASS     = 1,
    localparam int ADDR_W    = addr_w(NUM_REGS)
) (
    input  wire logic                  clk,
    input  wire logic                  rst,        // synchronous, active-low
    input  wire logic                  rs_en,      // already gated with RUN
    input  wire logic [ADDR_W-1:0]     rs_addr,
    input  wire logic [DATA_WIDTH-1:0] mem [NUM_REGS],
    input  wire logic                  wr_en,      // qualified write strobe
    input  wire logic [ADDR_W-1:0]     wr_addr,
    input  wire logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0]      rs_dout,
    output logic                       rs_valid
);

    logic [DATA_WIDTH-1:0] w_value;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_valid;

    // Select zero, forwarded write data, or stored value for this address
    always_comb begin
        w_hit   = (BYPASS != 0) && wr_en && (wr_addr == rs_addr);
        w_value = mem[rs_addr];
        if (rs_addr == ADDR_W'(REG_ZERO)) begin
            w_value = '0;
        end else if (w_hit) begin
            w_value = wr_data;
        end
    end

    // Capture read data on an accepted enable; data holds otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else if (rs_en) begin
            r_dout  <= w_value;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign rs_dout  = r_dout;
    assign rs_valid = r_valid;

endmodule : register_file_read_port
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_mp
//  Description : Parametrised N-read / 1-write integer register file with a
//                self-clearing start-up sequence and hardwired zero register.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,     // synchronous, active-low
    register_file_mp_if.slave bus
);

    localparam int ADDR_W = addr_w(NUM_REGS);

    logic [0:0]                     r_state;
    logic [ADDR_W-1:0]              r_clr_idx;
    logic [DATA_WIDTH-1:0]          r_mem [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0]          w_mem [NUM_REGS];
    logic                           w_run;
    logic                           w_wr_en;
    logic [NUM_READ-1:0]            w_rd_en;
    logic [DATA_WIDTH-1:0]          w_dout [NUM_READ];
    logic [NUM_READ*DATA_WIDTH-1:0] w_dout_packed;

    assign w_run   = (r_state == ST_RUN);
    assign w_wr_en = w_run && bus.rd_en && (bus.rd != ADDR_W'(REG_ZERO));
    assign w_rd_en = bus.rs_en & {NUM_READ{w_run}};

    // CLEAR walks clr_idx over 1..NUM_REGS-1 then hands over to RUN for good
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= ADDR_W'(1);
        end else if (r_state == ST_CLEAR) begin
            r_clr_idx <= r_clr_idx + ADDR_W'(1);
            if (r_clr_idx == ADDR_W'(NUM_REGS - 1)) begin
                r_state <= ST_RUN;
            end
        end
    end

    // Storage: zeroed one entry per cycle in CLEAR, written by writeback in RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_idx] <= '0;
            end else if (w_wr_en) begin
                r_mem[bus.rd] <= bus.rd_din;
            end
        end
    end

    // Full-width view of the array with entry 0 tied to zero
    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_view
            if (g == 0) begin : g_zero
                assign w_mem[g] = '0;
            end else begin : g_entry
                assign w_mem[g] = r_mem[g];
            end
        end
    endgenerate

    generate
        for (genvar p = 0; p < NUM_READ; p++) begin : g_read
            register_file_read_port #(
                .NUM_REGS   (NUM_REGS),
                .DATA_WIDTH (DATA_WIDTH),
                .BYPASS     (BYPASS)
            ) u_port (
                .clk      (clk),
                .rst      (rst),
                .rs_en    (w_rd_en[p]),
                .rs_addr  (bus.rs_addr[p*ADDR_W +: ADDR_W]),
                .mem      (w_mem),
                .wr_en    (w_wr_en),
                .wr_addr  (bus.rd),
                .wr_data  (bus.rd_din),
                .rs_dout  (w_dout[p]),
                .rs_valid (bus.rs_valid[p])
            );
        end
    endgenerate

    // Pack per-port read data onto the bus
    always_comb begin
        w_dout_packed = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            w_dout_packed[i*DATA_WIDTH +: DATA_WIDTH] = w_dout[i];
        end
    end

    assign bus.rs_dout = w_dout_packed;
    assign bus.ready   = w_run;

endmodule : register_file_mp
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_mp
//  Description : Self-checking bench for register_file_mp; expected read
//                data is queued per port when a read is issued and popped
//                when the matching rs_valid is observed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_mp;

    localparam int NUM_REGS   = 32;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_READ   = 2;
    localparam int BYPASS     = 1;
    localparam int CLEAR_LAT  = 31;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    always #5 clk = ~clk;

    register_file_mp_if #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_READ   (NUM_READ)
    ) bus ();

    register_file_mp #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_READ   (NUM_READ),
        .BYPASS     (BYPASS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // One clock of stimulus: queue expectations, clock, then check outputs
    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [1:0] ren, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] ev);
        logic [31:0] exp;
        bus.rd_en   = we;
        bus.rd      = wa;
        bus.rd_din  = wd;
        bus.rs_en   = ren;
        bus.rs_addr = {a1, a0};
        if (ev[0]) q0.push_back(e0);
        if (ev[1]) q1.push_back(e1);
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.rs_valid !== ev) begin
            n_err++;
            $display("FAIL rs_valid: got %b want %b (t=%0t)", bus.rs_valid, ev, $time);
        end
        if (bus.rs_valid[0] === 1'b1 && q0.size() > 0) begin
            exp = q0.pop_front();
            n_cmp++;
            if (bus.rs_dout[31:0] !== exp) begin
                n_err++;
                $display("FAIL port0 data: got %h want %h (t=%0t)", bus.rs_dout[31:0], exp, $time);
            end
        end
        if (bus.rs_valid[1] === 1'b1 && q1.size() > 0) begin
            exp = q1.pop_front();
            n_cmp++;
            if (bus.rs_dout[63:32] !== exp) begin
                n_err++;
                $display("FAIL port1 data: got %h want %h (t=%0t)", bus.rs_dout[63:32], exp, $time);
            end
        end
        bus.rd_en = 1'b0;
        bus.rs_en = 2'b00;
    endtask

    // Count edges after reset release until ready rises (bounded)
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
            if (bus.ready === 1'b1) break;
        end
    endtask

    task automatic test_reset;
        int cnt;
        rst = 1'b0;
        bus.rd_en = 1'b1; bus.rd = 5'd4; bus.rd_din = 32'hFFFF_FFFF;
        bus.rs_en = 2'b11; bus.rs_addr = {5'd4, 5'd4};
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.ready !== 1'b0) begin n_err++; $display("FAIL reset ready: got %b want 0", bus.ready); end
        n_cmp++;
        if (bus.rs_valid !== 2'b00) begin n_err++; $display("FAIL reset rs_valid: got %b want 00", bus.rs_valid); end
        n_cmp++;
        if (bus.rs_dout !== 64'h0) begin n_err++; $display("FAIL reset rs_dout: got %h want 0", bus.rs_dout); end
        bus.rd_en = 1'b0; bus.rs_en = 2'b00;
        rst = 1'b1;
        wait_ready(cnt);
        n_cmp++;
        if (cnt != CLEAR_LAT) begin n_err++; $display("FAIL clear latency: got %0d edges want %0d", cnt, CLEAR_LAT); end
    endtask

    task automatic test_clear_zero;
        for (int r = 0; r < NUM_REGS; r++) begin
            drive(1'b0, 5'd0, 32'h0, 2'b11, 5'(r), 5'(NUM_REGS-1-r), 32'h0, 32'h0, 2'b11);
        end
    endtask

    task automatic test_basic;
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00);
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11);
        drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0, 2'b01);
        drive(1'b0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd5, 32'h0, 32'hDEAD_BEEF, 2'b10);
    endtask

    task automatic test_zero_reg;
        drive(1'b1, 5'd0, 32'h1234_5678, 2'b11, 5'd0, 5'd0, 32'h0, 32'h0, 2'b11);
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 32'h0, 32'h0, 2'b11);
    endtask

    task automatic test_bypass;
        logic [31:0] same;
        same = (BYPASS != 0) ? 32'hA5A5_A5A5 : 32'h0000_0001;
        drive(1'b1, 5'd7, 32'h0000_0001, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00);
        drive(1'b1, 5'd7, 32'hA5A5_A5A5, 2'b11, 5'd7, 5'd7, same, same, 2'b11);
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd7, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 2'b11);
    endtask

    task automatic test_back_to_back;
        logic [31:0] v, vprev, vbyp;
        vprev = 32'h0;
        for (int k = 0; k < 6; k++) begin
            v    = 32'h1000_0000 + 32'(k * 32'h0101_0101);
            vbyp = (BYPASS != 0) ? v : 32'h0;
            // port 0 reads last cycle's register, port 1 the one being written now
            drive(1'b1, 5'(10 + k), v, 2'b11, (k == 0) ? 5'd5 : 5'(9 + k), 5'(10 + k),
                  (k == 0) ? 32'hDEAD_BEEF : vprev, vbyp, 2'b11);
            vprev = v;
        end
    endtask

    task automatic test_ignore_clear;
        int cnt;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 5'd3, 32'h0000_00FF, 2'b11, 5'd3, 5'd3, 32'h0, 32'h0, 2'b00);
        end
        wait_ready(cnt);
        n_cmp++;
        if (cnt != CLEAR_LAT - 8) begin
            n_err++; $display("FAIL clear latency after busy clear: got %0d want %0d", cnt, CLEAR_LAT - 8);
        end
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd3, 32'h0, 32'h0, 2'b11);
    endtask

    task automatic test_reset_mid;
        int cnt;
        drive(1'b1, 5'd9, 32'h0000_0055, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00);
        drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd9, 5'd0, 32'h0000_0055, 32'h0, 2'b01);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.ready !== 1'b0) begin n_err++; $display("FAIL ready after mid reset: got %b want 0", bus.ready); end
        rst = 1'b1;
        wait_ready(cnt);
        n_cmp++;
        if (cnt != CLEAR_LAT) begin n_err++; $display("FAIL re-clear latency: got %0d want %0d", cnt, CLEAR_LAT); end
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd7, 32'h0, 32'h0, 2'b11);
    endtask

    initial begin
        bus.rd_en   = 1'b0;
        bus.rd      = '0;
        bus.rd_din  = '0;
        bus.rs_en   = '0;
        bus.rs_addr = '0;
        test_reset();
        test_clear_zero();
        test_basic();
        test_zero_reg();
        test_bypass();
        test_back_to_back();
        test_ignore_clear();
        test_reset_mid();
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: %0d/%0d entries left want 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule : tb_register_file_mp
`default_nettype wire
